// File: rtl/jt12_dac_ser_if.sv
// Sample bus from the channel accumulator to the serial DAC transmitter.
// One signed left/right pair is offered per sample_valid strobe.
interface jt12_dac_ser_if #(
    parameter int W = 12
);
    logic                sample_valid;
    logic signed [W-1:0] left;
    logic signed [W-1:0] right;

    modport master (output sample_valid, left, right);
    modport slave  (input  sample_valid, left, right);
endinterface

// File: rtl/jt12_dac_ser.sv
// Left-justified, MSB-first stereo serial transmitter (bclk/lrck/sdata) fed from a
// single holding register; all timing is derived from clk_en.
module jt12_dac_ser #(
    parameter int W        = 12,
    parameter int SLOT     = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    jt12_dac_ser_if.slave    smp,
    input  logic             clr_flags,
    output logic             bclk,
    output logic             lrck,
    output logic             sdata,
    output logic             underrun,
    output logic             overrun
);
    localparam int FW    = 2 * SLOT;
    localparam int BW    = $clog2(FW);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [W-1:0]     hold_l;
    logic [W-1:0]     hold_r;
    logic             hold_valid;
    logic [FW-1:0]    shreg;

    logic             tog;
    logic             fall;
    logic             frame_start;
    logic             capture;
    logic [BW-1:0]    bit_nxt;
    logic [FW-1:0]    frame_word;
    logic             ur_set;
    logic             ov_set;

    always_comb begin
        tog         = clk_en && (div_cnt == DIV_W'(BCLK_DIV - 1));
        fall        = tog && bclk;
        bit_nxt     = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
        frame_start = fall && (bit_nxt == '0);
        capture     = clk_en && smp.sample_valid;
        // Both slots left-justified and zero padded, left slot in the upper half
        frame_word                = '0;
        frame_word[FW-1 -: W]     = hold_l;
        frame_word[SLOT-1 -: W]   = hold_r;
        ur_set      = frame_start && !hold_valid;
        ov_set      = capture && hold_valid && !frame_start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            bit_cnt    <= BW'(FW - 1);
            lrck       <= 1'b0;
            sdata      <= 1'b0;
            shreg      <= '0;
            hold_l     <= '0;
            hold_r     <= '0;
            hold_valid <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (clk_en) begin
                div_cnt <= tog ? '0 : div_cnt + 1'b1;
                if (tog)
                    bclk <= ~bclk;
                underrun <= ur_set | (underrun & ~clr_flags);
                overrun  <= ov_set | (overrun & ~clr_flags);
            end

            if (fall) begin
                bit_cnt <= bit_nxt;
                lrck    <= (bit_nxt >= BW'(SLOT));
                // The frame-start bit comes straight from the freshly loaded word
                if (frame_start) begin
                    sdata <= frame_word[FW-1];
                    shreg <= frame_word << 1;
                end else begin
                    sdata <= shreg[FW-1];
                    shreg <= shreg << 1;
                end
            end

            if (capture) begin
                hold_l     <= smp.left;
                hold_r     <= smp.right;
                hold_valid <= 1'b1;
            end else if (frame_start) begin
                hold_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jt12_dac_ser.sv
// Bench for jt12_dac_ser at BCLK_DIV=1, SLOT=16, W=12: directed stimulus pushes expected
// frames into a queue, a monitor deserialises sdata frame by frame and compares.
module tb_jt12_dac_ser;
    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    logic clr_flags;
    logic bclk, lrck, sdata, underrun, overrun;

    int vectors = 0;
    int errors  = 0;
    int T       = 0;
    int cyc     = 0;
    bit toggle  = 1'b0;

    typedef struct packed {
        logic [11:0] l;
        logic [11:0] r;
        logic        ur;
        logic        ov;
    } exp_t;
    exp_t q[$];

    jt12_dac_ser_if #(.W(12)) sif ();

    jt12_dac_ser #(.W(12), .SLOT(16), .BCLK_DIV(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .smp       (sif.slave),
        .clr_flags (clr_flags),
        .bclk      (bclk),
        .lrck      (lrck),
        .sdata     (sdata),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at T=%0d: got %h expected %h", name, T, act, exp);
        end
    endtask

    task automatic tick_in(input logic sv, input logic [11:0] l, input logic [11:0] r,
                           input logic clr);
        if (toggle) begin
            @(negedge clk);
            clk_en = 1'b0;
            sif.sample_valid = 1'b0;
            clr_flags = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        clk_en = 1'b1;
        sif.sample_valid = sv;
        sif.left = l;
        sif.right = r;
        clr_flags = clr;
        @(posedge clk);
        T++;
    endtask

    task automatic tick();
        tick_in(1'b0, 12'h000, 12'h000, 1'b0);
    endtask

    task automatic go_to(input int n);
        while (T < n) tick();
    endtask

    task automatic do_reset(input int n, input logic en);
        @(negedge clk);
        rst_n = 1'b0;
        clk_en = en;
        sif.sample_valid = 1'b0;
        clr_flags = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        clk_en = 1'b0;
        T = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bclk"},     {31'd0, bclk},     32'd0);
        check({tag, "_lrck"},     {31'd0, lrck},     32'd0);
        check({tag, "_sdata"},    {31'd0, sdata},    32'd0);
        check({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
        check({tag, "_overrun"},  {31'd0, overrun},  32'd0);
    endtask

    // Monitor: the first bclk fall after reset, and every 32nd fall after it, starts a frame
    initial begin : monitor
        int          fidx;
        int          nframe;
        logic        pb;
        logic [31:0] word;
        logic        ur_s, ov_s, lr_bad;
        exp_t        e;
        fidx = 0; nframe = 0; pb = 1'b0; word = '0;
        ur_s = 1'b0; ov_s = 1'b0; lr_bad = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                fidx = 0;
                pb = 1'b0;
            end else begin
                if (pb && !bclk) begin
                    if (fidx == 0) begin
                        ur_s = underrun;
                        ov_s = overrun;
                        lr_bad = 1'b0;
                    end
                    word[31-fidx] = sdata;
                    if (lrck !== (fidx >= 16)) lr_bad = 1'b1;
                    fidx++;
                    if (fidx == 32) begin
                        fidx = 0;
                        if (q.size() == 0) begin
                            check($sformatf("frame%0d_unexpected", nframe), 32'd1, 32'd0);
                        end else begin
                            e = q.pop_front();
                            check($sformatf("frame%0d_data", nframe), word,
                                  {e.l, 4'h0, e.r, 4'h0});
                            check($sformatf("frame%0d_lrck_bad", nframe), {31'd0, lr_bad}, 32'd0);
                            check($sformatf("frame%0d_underrun", nframe), {31'd0, ur_s},
                                  {31'd0, e.ur});
                            check($sformatf("frame%0d_overrun", nframe), {31'd0, ov_s},
                                  {31'd0, e.ov});
                        end
                        nframe++;
                    end
                end
                pb = bclk;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int   c0;
        logic pbc;
        bit   done;
        rst_n = 1'b0; clk_en = 1'b0; clr_flags = 1'b0;
        sif.sample_valid = 1'b0; sif.left = '0; sif.right = '0;

        // Reset with clk_en high, then first bclk rise/fall
        do_reset(3, 1'b1);
        check_all_zero("rst1");
        release_rst();
        q.push_back('{12'h000, 12'h000, 1'b1, 1'b0});
        tick(); #1;
        check("t1_bclk_rise", {31'd0, bclk}, 32'd1);
        tick(); #1;
        check("t2_bclk_fall", {31'd0, bclk}, 32'd0);
        check("t2_lrck", {31'd0, lrck}, 32'd0);
        check("t2_underrun", {31'd0, underrun}, 32'd1);

        // Extreme values, then clear the frame-0 underrun
        go_to(29); tick_in(1'b1, 12'h7FF, 12'h800, 1'b0);
        q.push_back('{12'h7FF, 12'h800, 1'b0, 1'b0});
        go_to(39); tick_in(1'b0, 12'h000, 12'h000, 1'b1); #1;
        check("t40_underrun_clr", {31'd0, underrun}, 32'd0);
        go_to(66); #1;
        check("t66_overrun", {31'd0, overrun}, 32'd0);

        // No new strobe: resend with underrun; clear and observe it stays low
        q.push_back('{12'h7FF, 12'h800, 1'b1, 1'b0});
        go_to(139); tick_in(1'b0, 12'h000, 12'h000, 1'b1); #1;
        check("t140_underrun", {31'd0, underrun}, 32'd0);
        tick(); #1;
        check("t141_underrun", {31'd0, underrun}, 32'd0);

        // Two strobes in one frame: overrun, newer wins
        go_to(149); tick_in(1'b1, 12'h123, 12'h456, 1'b0); #1;
        check("t150_overrun", {31'd0, overrun}, 32'd0);
        go_to(159); tick_in(1'b1, 12'h0AB, 12'hFED, 1'b0); #1;
        check("t160_overrun", {31'd0, overrun}, 32'd1);
        q.push_back('{12'h0AB, 12'hFED, 1'b0, 1'b1});
        go_to(193); #1;
        check("t193_underrun", {31'd0, underrun}, 32'd0);
        go_to(199); tick_in(1'b0, 12'h000, 12'h000, 1'b1);

        // Strobe on the frame-start tick with the hold register already valid
        go_to(229); tick_in(1'b1, 12'h246, 12'h135, 1'b0);
        q.push_back('{12'h246, 12'h135, 1'b0, 1'b0});
        go_to(257); tick_in(1'b1, 12'h5A5, 12'hA5A, 1'b0); #1;
        check("t258_overrun", {31'd0, overrun}, 32'd0);
        q.push_back('{12'h5A5, 12'hA5A, 1'b0, 1'b0});

        // clk_en toggling: same bits, bclk period doubles in clk cycles
        go_to(329); tick_in(1'b1, 12'h3C3, 12'hC3C, 1'b0);
        q.push_back('{12'h3C3, 12'hC3C, 1'b0, 1'b0});
        go_to(340);
        toggle = 1'b1;
        c0 = -1; pbc = bclk; done = 1'b0;
        repeat (10) begin
            tick(); #1;
            if (!done && bclk && !pbc) begin
                if (c0 >= 0) begin
                    check("bclk_period_clk", cyc - c0, 32'd4);
                    done = 1'b1;
                end
                c0 = cyc;
            end
            pbc = bclk;
        end
        check("bclk_period_seen", {31'd0, done}, 32'd1);

        // Pending sample, then reset in the middle of the right slot
        go_to(459); tick_in(1'b1, 12'h111, 12'h222, 1'b0);
        go_to(490); #1;
        check("t490_lrck_right", {31'd0, lrck}, 32'd1);
        do_reset(2, 1'b0);
        toggle = 1'b0;
        check_all_zero("rst2");
        release_rst();
        q.push_back('{12'h000, 12'h000, 1'b1, 1'b0});
        go_to(70);
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
